// File: rtl/rf_writeback_ctrl.sv
// Write-side front end for the dual-write-port register file: in-order result queue, paired drain,
// x0 drop, same-rd resolution and pending-write mask. Optional WB_BYPASS_EN skips the empty queue.
module rf_writeback_ctrl #(
    parameter int RS    = 5,
    parameter int RD    = 32,
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           res_valid,
    input  logic [1:0][RS-1:0]   res_rd,
    input  logic [1:0][RD-1:0]   res_wd,
    output logic                 res_ready,
    input  logic                 wb_stall,
    output logic [1:0]           wb_en,
    output logic [1:0][RS-1:0]   wb_rd,
    output logic [1:0][RD-1:0]   wb_wd,
    output logic [31:0]          pend_mask
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d, push_n, pop_n;
    logic [1:0]            wb_en_q, wb_en_d;
    logic [1:0][RS-1:0]    wb_rd_q, wb_rd_d;
    logic [1:0][RD-1:0]    wb_wd_q, wb_wd_d;
    logic [RS-1:0]         mem_rd_q [DEPTH];
    logic [RD-1:0]         mem_wd_q [DEPTH];

    logic [1:0]            keep, we;
    logic [1:0][PW-1:0]    wa;
    logic [1:0][RS-1:0]    slot_rd, cand_rd;
    logic [1:0][RD-1:0]    slot_wd, cand_wd;
    logic [1:0]            cand_n;
    logic                  bypass;
    logic [31:0]           pend_c;
    logic [PW-1:0]         off;

    assign res_ready = (count_q <= CW'(DEPTH - 2));
    assign keep[0]   = res_valid[0] & res_ready & (res_rd[0] != '0);
    assign keep[1]   = res_valid[1] & res_ready & (res_rd[1] != '0);

    always_comb begin
        pop_n   = '0;
        push_n  = '0;
        cand_n  = 2'd0;
        bypass  = 1'b0;
        wb_en_d = 2'b00;
        wb_rd_d = wb_rd_q;
        wb_wd_d = wb_wd_q;
        cand_rd[0] = mem_rd_q[rd_ptr_q];
        cand_wd[0] = mem_wd_q[rd_ptr_q];
        cand_rd[1] = mem_rd_q[rd_ptr_q + PW'(1)];
        cand_wd[1] = mem_wd_q[rd_ptr_q + PW'(1)];
        if (!wb_stall) begin
            if (count_q >= CW'(2)) begin
                cand_n = 2'd2;
                pop_n  = CW'(2);
            end else if (count_q == CW'(1)) begin
                cand_n = 2'd1;
                pop_n  = CW'(1);
            end
`ifdef WB_BYPASS_EN
            if (count_q == '0 && keep != 2'b00) begin
                bypass     = 1'b1;
                cand_n     = (keep == 2'b11) ? 2'd2 : 2'd1;
                cand_rd[0] = keep[0] ? res_rd[0] : res_rd[1];
                cand_wd[0] = keep[0] ? res_wd[0] : res_wd[1];
                cand_rd[1] = res_rd[1];
                cand_wd[1] = res_wd[1];
            end
`endif
            // The younger entry wins a same-destination pair; the older write is squashed.
            case (cand_n)
                2'd2: begin
                    wb_en_d = (cand_rd[0] == cand_rd[1]) ? 2'b10 : 2'b11;
                    wb_rd_d = cand_rd;
                    wb_wd_d = cand_wd;
                end
                2'd1: begin
                    wb_en_d    = 2'b01;
                    wb_rd_d[0] = cand_rd[0];
                    wb_wd_d[0] = cand_wd[0];
                end
                default: ;
            endcase
        end

        we      = 2'b00;
        wa[0]   = wr_ptr_q;
        wa[1]   = wr_ptr_q + PW'(1);
        slot_rd = res_rd;
        slot_wd = res_wd;
        if (!bypass) begin
            case (keep)
                2'b11: begin
                    we     = 2'b11;
                    push_n = CW'(2);
                end
                2'b01: begin
                    we     = 2'b01;
                    push_n = CW'(1);
                end
                2'b10: begin
                    we         = 2'b01;
                    push_n     = CW'(1);
                    slot_rd[0] = res_rd[1];
                    slot_wd[0] = res_wd[1];
                end
                default: ;
            endcase
        end
        wr_ptr_d = wr_ptr_q + PW'(push_n);
        rd_ptr_d = rd_ptr_q + PW'(pop_n);
        count_d  = count_q + push_n - pop_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            wb_en_q  <= '0;
            wb_rd_q  <= '0;
            wb_wd_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            wb_en_q  <= wb_en_d;
            wb_rd_q  <= wb_rd_d;
            wb_wd_q  <= wb_wd_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    mem_rd_q[wa[gi]] <= slot_rd[gi];
                    mem_wd_q[wa[gi]] <= slot_wd[gi];
                end
            end
        end
    endgenerate

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        pend_c = '0;
        off    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr_q;
            if ({1'b0, off} < count_q) pend_c[mem_rd_q[i]] = 1'b1;
        end
        for (int p = 0; p < 2; p++) begin
            if (wb_en_q[p]) pend_c[wb_rd_q[p]] = 1'b1;
        end
        pend_c[0] = 1'b0;
    end

    assign pend_mask = pend_c;
    assign wb_en     = wb_en_q;
    assign wb_rd     = wb_rd_q;
    assign wb_wd     = wb_wd_q;
endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Randomized bench for rf_writeback_ctrl against a queue-based reference model; honours WB_BYPASS_EN.
module tb_rf_writeback_ctrl;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] wd;
    } ent_t;

    logic              clk;
    logic              rst;
    logic [1:0]        res_valid;
    logic [1:0][4:0]   res_rd;
    logic [1:0][31:0]  res_wd;
    logic              res_ready;
    logic              wb_stall;
    logic [1:0]        wb_en;
    logic [1:0][4:0]   wb_rd;
    logic [1:0][31:0]  wb_wd;
    logic [31:0]       pend_mask;

    int n_cmp = 0;
    int n_err = 0;

    ent_t        q[$];
    logic [1:0]  exp_en;
    logic [4:0]  exp_rd [2];
    logic [31:0] exp_wd [2];

    rf_writeback_ctrl #(.RS(5), .RD(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .res_valid(res_valid), .res_rd(res_rd), .res_wd(res_wd), .res_ready(res_ready),
        .wb_stall(wb_stall),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_wd(wb_wd),
        .pend_mask(pend_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        exp_en = 2'b00;
        exp_rd[0] = '0; exp_rd[1] = '0;
        exp_wd[0] = '0; exp_wd[1] = '0;
    endtask

    // Wait for the negedge, then compare every output against the model state after the last posedge.
    task automatic tick();
        logic [31:0] m;
        @(negedge clk);
        m = '0;
        foreach (q[k]) m[q[k].rd] = 1'b1;
        for (int p = 0; p < 2; p++) if (exp_en[p]) m[exp_rd[p]] = 1'b1;
        m[0] = 1'b0;
        check_eq("res_ready", 64'(res_ready), 64'(q.size() <= DEPTH - 2));
        check_eq("wb_en", 64'(wb_en), 64'(exp_en));
        check_eq("pend_mask", 64'(pend_mask), 64'(m));
        for (int p = 0; p < 2; p++) begin
            if (exp_en[p]) begin
                check_eq($sformatf("wb_rd%0d", p), 64'(wb_rd[p]), 64'(exp_rd[p]));
                check_eq($sformatf("wb_wd%0d", p), 64'(wb_wd[p]), 64'(exp_wd[p]));
            end
        end
        $display("t=%0t en=%b rd=%0d/%0d wd=%0h/%0h rdy=%b qlen=%0d", $time, wb_en,
                 wb_rd[0], wb_rd[1], wb_wd[0], wb_wd[1], res_ready, q.size());
    endtask

    // Drive inputs for the coming posedge and advance the model by one cycle.
    task automatic drive(input logic [1:0] v, input logic [4:0] r0, input logic [31:0] d0,
                         input logic [4:0] r1, input logic [31:0] d1, input logic st);
        ent_t kept[$];
        ent_t drn[$];
        bit   rdy;
        res_valid = v;
        res_rd[0] = r0; res_wd[0] = d0;
        res_rd[1] = r1; res_wd[1] = d1;
        wb_stall  = st;
        rdy = (q.size() <= DEPTH - 2);
        if (v[0] && rdy && r0 != 0) kept.push_back(ent_t'{r0, d0});
        if (v[1] && rdy && r1 != 0) kept.push_back(ent_t'{r1, d1});
        if (!st) begin
`ifdef WB_BYPASS_EN
            if (q.size() == 0) begin
                drn = kept;
                kept.delete();
            end
`endif
            while (drn.size() < 2 && q.size() > 0) drn.push_back(q.pop_front());
        end
        foreach (kept[k]) q.push_back(kept[k]);
        exp_en = 2'b00;
        if (drn.size() == 2) begin
            exp_en = (drn[0].rd == drn[1].rd) ? 2'b10 : 2'b11;
            exp_rd[0] = drn[0].rd; exp_wd[0] = drn[0].wd;
            exp_rd[1] = drn[1].rd; exp_wd[1] = drn[1].wd;
        end else if (drn.size() == 1) begin
            exp_en = 2'b01;
            exp_rd[0] = drn[0].rd; exp_wd[0] = drn[0].wd;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b0;
        res_valid = '0; res_rd = '0; res_wd = '0; wb_stall = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        check_eq("rst_wb_en", 64'(wb_en), 64'd0);
        check_eq("rst_ready", 64'(res_ready), 64'd1);
        check_eq("rst_pend", 64'(pend_mask), 64'd0);
        rst = 1'b1;

        // single result on lane 0
        tick(); drive(2'b01, 5'd5, 32'h1234, 5'd0, 32'd0, 1'b0);
        tick(); check_eq("single_pend5", 64'(pend_mask[5]), 64'd1);
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        idle(3);

        // same-rd pair, then x0 drop
        tick(); drive(2'b11, 5'd7, 32'd1, 5'd7, 32'd2, 1'b0);
        idle(3);
        tick(); drive(2'b11, 5'd0, 32'hFF, 5'd3, 32'd9, 1'b0);
        idle(3);

        // backpressure: fill under stall, then release
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 3) check_eq("bp_ready_cnt6", 64'(res_ready), 64'd1);
            drive(2'b11, 5'(2 * k + 1), 32'(100 + 2 * k), 5'(2 * k + 2), 32'(101 + 2 * k), 1'b1);
        end
        tick(); check_eq("bp_ready_full", 64'(res_ready), 64'd0);
        drive(2'b11, 5'd9, 32'd9, 5'd10, 32'd10, 1'b0);
        tick(); check_eq("bp_first_rd0", 64'(wb_rd[0]), 64'd1);
        check_eq("bp_first_rd1", 64'(wb_rd[1]), 64'd2);
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        idle(5);

        // randomized traffic with a mid-stream reset
        for (int it = 0; it < 2000; it++) begin
            tick();
            drive(2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 9)), $urandom,
                  5'($urandom_range(0, 9)), $urandom,
                  ($urandom_range(0, 9) < 3));
            if (it == 1000) begin
                #2;
                rst = 1'b0;
                res_valid = '0;
                wb_stall = 1'b0;
                #1;
                check_eq("midrst_wb_en", 64'(wb_en), 64'd0);
                check_eq("midrst_ready", 64'(res_ready), 64'd1);
                check_eq("midrst_pend", 64'(pend_mask), 64'd0);
                model_clear();
                @(negedge clk);
                rst = 1'b1;
            end
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
